// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity modes and counter sizing helper.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter with synchronous clear, pulses bit_end on terminal count.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);
  import uart_pkg::*;
  localparam int CW = cnt_w(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clear || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (start, data LSB first, optional parity, 1-2 stops).
// Optional line-break support is enabled by defining UART_TX_BREAK_EN (adds the brk input).
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  input  logic [DATA_BITS-1:0] s_data,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 s_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  import uart_pkg::*;
  state_t state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [3:0] bit_cnt, bit_n;
  logic par, par_n, tx_n, bit_end;
  assign s_ready = state == IDLE;
  assign busy = state != IDLE;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state == IDLE || state == BREAK),
    .bit_end(bit_end)
  );
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n = bit_cnt;
    par_n = par;
    done = 1'b0;
    case (state)
      IDLE:
        if (s_valid) begin
          state_n = START;
          shift_n = s_data;
          par_n = (^s_data) ^ (PARITY == PAR_ODD);
          bit_n = '0;
        end
`ifdef UART_TX_BREAK_EN
        else if (brk) state_n = BREAK;
`endif
      START: if (bit_end) state_n = DATA;
      DATA:
        if (bit_end) begin
          shift_n = shift >> 1;
          bit_n = bit_cnt + 1'b1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_n = '0;
            state_n = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
          end
        end
      uart_pkg::PARITY: if (bit_end) state_n = STOP;
      STOP:
        if (bit_end) begin
          bit_n = bit_cnt + 1'b1;
          if (bit_cnt == 4'(STOP_BITS - 1)) begin
            bit_n = '0;
            state_n = IDLE;
            done = 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
      BREAK: if (!brk) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
    // tx is registered, so it is derived from the state being entered
    tx_n = (state_n == START || state_n == BREAK) ? 1'b0 :
           (state_n == DATA) ? shift_n[0] :
           (state_n == uart_pkg::PARITY) ? par_n : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      par <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_n;
      par <= par_n;
      tx <= tx_n;
    end
  always @(posedge clk)
    assert (PARITY <= PAR_ODD && (STOP_BITS == 1 || STOP_BITS == 2) &&
            DATA_BITS >= 5 && DATA_BITS <= 9 && CLKS_PER_BIT >= 2)
    else $error("uart_tx_frame: illegal parameter set");
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: several uart_tx_frame configurations checked cycle by cycle against a frame model.
module tb_uart_tx_frame;
  localparam int N = 5;
  localparam int CPB[N] = '{4, 4, 4, 3, 5};
  localparam int DB[N]  = '{8, 8, 8, 5, 9};
  localparam int PAR[N] = '{0, 1, 2, 0, 2};
  localparam int SB[N]  = '{1, 1, 1, 2, 2};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] valid, ready, tx, busy, done;
  logic [8:0] data [N];
`ifdef UART_TX_BREAK_EN
  logic [N-1:0] brk;
`endif
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_frame #(
      .CLKS_PER_BIT(CPB[g]),
      .DATA_BITS(DB[g]),
      .PARITY(PAR[g]),
      .STOP_BITS(SB[g])
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_valid(valid[g]),
      .s_data(data[g][DB[g]-1:0]),
`ifdef UART_TX_BREAK_EN
      .brk(brk[g]),
`endif
      .s_ready(ready[g]),
      .tx(tx[g]),
      .busy(busy[g]),
      .done(done[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int flen(input int k);
    return (1 + DB[k] + (PAR[k] != 0 ? 1 : 0) + SB[k]) * CPB[k];
  endfunction
  // Line level of bit slot b of a frame carrying w, built from the frame layout
  function automatic logic exp_bit(input int k, input logic [8:0] w, input int b);
    logic [8:0] m;
    int ones;
    m = 9'((1 << DB[k]) - 1);
    ones = $countones(w & m) % 2;
    if (b == 0) return 1'b0;
    if (b <= DB[k]) return w[b-1];
    if (PAR[k] != 0 && b == DB[k] + 1) return (PAR[k] == 1) ? ones[0] : !ones[0];
    return 1'b1;
  endfunction
  task automatic send(input int k, input logic [8:0] w, input bit hold);
    @(negedge clk);
    valid[k] = 1'b1;
    data[k] = w;
    @(posedge clk);
    #1;
    if (!hold) valid[k] = 1'b0;
    data[k] = 9'($urandom);
  endtask
  task automatic expect_frame(input int k, input logic [8:0] w, input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      chk($sformatf("c%0d_tx_cyc%0d", k, i), tx[k], exp_bit(k, w, i / CPB[k]));
      chk($sformatf("c%0d_done_cyc%0d", k, i), done[k], (i == flen(k) - 1) ? 1 : 0);
      chk($sformatf("c%0d_busy_cyc%0d", k, i), busy[k], 1);
      chk($sformatf("c%0d_ready_cyc%0d", k, i), ready[k], 0);
    end
  endtask
  task automatic expect_idle(input int k);
    @(negedge clk);
    chk($sformatf("c%0d_idle_tx", k), tx[k], 1);
    chk($sformatf("c%0d_idle_busy", k), busy[k], 0);
    chk($sformatf("c%0d_idle_ready", k), ready[k], 1);
    chk($sformatf("c%0d_idle_done", k), done[k], 0);
  endtask
  initial begin
    logic [8:0] w;
    valid = '0;
    for (int k = 0; k < N; k++) data[k] = '0;
`ifdef UART_TX_BREAK_EN
    brk = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, {N{1'b1}});
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, {N{1'b1}});
    rst_n = 1'b1;
    send(0, 9'h0A5, 0);
    expect_frame(0, 9'h0A5, 0, flen(0));
    expect_idle(0);
    send(1, 9'h007, 0);
    expect_frame(1, 9'h007, 0, flen(1));
    expect_idle(1);
    send(2, 9'h007, 0);
    expect_frame(2, 9'h007, 0, flen(2));
    expect_idle(2);
    send(3, 9'h01F, 0);
    expect_frame(3, 9'h01F, 0, flen(3));
    expect_idle(3);
    for (int k = 0; k < N; k++)
      repeat (3) begin
        w = 9'($urandom);
        send(k, w, 0);
        expect_frame(k, w, 0, flen(k));
        expect_idle(k);
      end
    send(0, 9'h000, 1);
    expect_frame(0, 9'h000, 0, flen(0));
    data[0] = 9'h0FF;
    expect_idle(0);
    @(posedge clk);
    #1 valid[0] = 1'b0;
    expect_frame(0, 9'h0FF, 0, flen(0));
    expect_idle(0);
    w = 9'($urandom) & ~9'h008;
    send(0, w, 0);
    expect_frame(0, w, 0, 18);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx[0], 1);
    chk("async_rst_busy", busy[0], 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", done[0], 0);
      chk("rst_hold_tx", tx[0], 1);
    end
    rst_n = 1'b1;
    send(0, 9'h03C, 0);
    expect_frame(0, 9'h03C, 0, flen(0));
    expect_idle(0);
`ifdef UART_TX_BREAK_EN
    w = 9'($urandom);
    send(0, w, 0);
    expect_frame(0, w, 0, 10);
    brk[0] = 1'b1;
    expect_frame(0, w, 10, flen(0));
    expect_idle(0);
    @(negedge clk);
    chk("brk_tx", tx[0], 0);
    chk("brk_ready", ready[0], 0);
    chk("brk_busy", busy[0], 1);
    valid[0] = 1'b1;
    data[0] = 9'($urandom);
    repeat (4) begin
      @(negedge clk);
      chk("brk_block_ready", ready[0], 0);
      chk("brk_block_tx", tx[0], 0);
    end
    valid[0] = 1'b0;
    brk[0] = 1'b0;
    expect_idle(0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
